sqrt_result_serializer: RTL and testbench
=========================================

Name: sqrt_result_serializer

Overview:
- Downstream stage of the integer square-root core.
- Captures each finished result (root `vout`, remainder `rout`) on the `calcend` pulse into a 2-entry result buffer.
- Splits each result into DATAOUT-bit words and writes them, LSW first, into the output FIFO with a write-enable/full handshake.
- Absorbs FIFO back-pressure so the core can finish a second result while the first is still draining.

Parameters:
- DATAOUT, 48: output word width.
- VW, 128: root (`vout`) width.
- RW, 129: remainder (`rout`) width.
- WORDS, ceil((VW+RW)/DATAOUT) = 6: words emitted per result (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- vout  input  VW  root from the sqrt core; valid in the `calcend` cycle.
- rout  input  RW  remainder from the sqrt core; valid in the `calcend` cycle.
- calcend  input  1  one-cycle pulse, result valid.
- full  input  1  output FIFO full/almost-full; must assert with ≥1 word of headroom.
- dataout  output  DATAOUT  word to the FIFO.
- wren  output  1  FIFO write strobe; one word per high cycle.
- busy  output  1  high while any result is buffered or a word is being written.
- overflow  output  1  sticky: a result was dropped.

Behaviour:
- Reset (async assert, sync release): `wren`=0, `dataout`=0, `busy`=0, `overflow`=0.
  - Buffer is emptied, FSM goes to IDLE, word index = 0.
  - Reset mid-stream discards every buffered and partially sent result; no further words after release until a new `calcend`.
- Packing:
  - P = {zero pad, rout, vout}, WORDS*DATAOUT = 288 bits.
  - `vout` occupies bits [127:0]; `rout` occupies bits [256:128]; pad bits are 0.
  - Word k = P[48k+47:48k]; emitted in order k = 0..5.
- Capture:
  - On an edge with `calcend`=1, {`vout`,`rout`} is written into the next free buffer entry.
  - The buffer is a 2-entry FIFO with write pointer, read pointer and count.
- FSM states: IDLE, SEND.
  - IDLE → SEND when count > 0.
  - In SEND, on each edge with `full`=0: register `dataout` = word[idx] of the head entry, set `wren`=1, idx++.
  - On each edge with `full`=1: `wren`=0, idx held, `dataout` held.
  - After word 5 is issued: idx → 0 and the head entry is popped.
    - If count after the pop is > 0, stay in SEND; the next result starts on the very next cycle with no gap.
    - Otherwise go to IDLE.
- Latency: with the FSM idle and `full` low, `calcend` sampled at edge E gives `wren`=1 with word0 after edge E+2. Words 0..5 then follow on consecutive cycles.
- `full` is sampled registered: a word is written in the cycle after `full` was seen low. The FIFO provides the headroom for this.
- Boundary cases:
  - `calcend` with count = 2 and no pop on the same edge: the result is dropped, `overflow` sets to 1 and stays set until reset, and buffer contents are unchanged.
  - `calcend` on the same edge as the pop of word 5 with count = 2: the result is accepted (pop before push); `overflow` stays 0.
  - `calcend` arriving while the FSM is in SEND: the result is queued and does not disturb the word currently being sent.
- `busy` = (count ≠ 0) OR `wren`.

Test Plan:
- Single result: `vout`=128'h0123456789ABCDEF_FEDCBA9876543210, `rout`=0, `full`=0 → `wren` high for 6 consecutive cycles starting 2 edges after `calcend`. Words in order: 48'hBA9876543210, 48'h89ABCDEFFEDC, 48'h000001234567, 0, 0, 0. `busy` falls the cycle after the last word.
- Remainder packing: `vout`=0, `rout`=all ones → words: 0, 0, 48'hFFFF00000000, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'h00000001FFFF.
- Back-pressure: `full`=1 for 5 cycles after word1 is sent → no `wren` during the stall; word2 follows once `full` drops; total 6 writes, no duplicates or skips.
- Back-to-back results: two `calcend` pulses 3 cycles apart → 12 consecutive writes, result A then result B, no idle cycle between them; `overflow`=0.
- Overflow and simultaneous events:
  - Hold `full`=1 and issue 3 `calcend` pulses → `overflow`=1; after `full` drops, only results 1 and 2 are emitted.
  - Separately, a third `calcend` on the pop edge of word 5 is accepted with `overflow`=0.
- Reset mid-stream: assert `reset_n`=0 after word 3 → `wren`=0 and `dataout`=0 immediately; after release no writes occur until a new `calcend`.

Source files
------------

// File: rtl/sqrt_result_serializer.sv
// Result serializer behind the integer square-root core: buffers up to two
// {rout, vout} results and streams each one as LSW-first words into a FIFO.
module sqrt_result_serializer #(
    parameter int unsigned DATAOUT = 48,
    parameter int unsigned VW      = 128,
    parameter int unsigned RW      = 129
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [VW-1:0]      vout,
    input  logic [RW-1:0]      rout,
    input  logic               calcend,
    input  logic               full,
    output logic [DATAOUT-1:0] dataout,
    output logic               wren,
    output logic               busy,
    output logic               overflow
);

    localparam int unsigned EW    = VW + RW;
    localparam int unsigned WORDS = (EW + DATAOUT - 1) / DATAOUT;
    localparam int unsigned PW    = WORDS * DATAOUT;
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATAOUT-1:0]   dataout_q, dataout_d;
    logic                 wren_q, wren_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 push, pop;
    logic [EW-1:0]        entry_q [2];
    logic [WORDS-1:0][DATAOUT-1:0] head_words;

    // Head entry viewed as zero-padded words; vout sits in the low bits
    assign head_words = PW'(entry_q[rd_ptr_q]);

    // Next-state: word issue, buffer pop-before-push, drop detection
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dataout_d = dataout_q;
        wren_d    = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != 2'd0) state_d = StSend;
            end
            StSend: begin
                if (!full) begin
                    dataout_d = head_words[idx_q];
                    wren_d    = 1'b1;
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        pop   = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A pop on this edge frees a slot for a simultaneous capture
        push       = calcend && ((count_q != 2'd2) || pop);
        overflow_d = overflow_q | (calcend & ~push);
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Chain straight into the next buffered result with no idle cycle
        if (pop && (count_d == 2'd0)) state_d = StIdle;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            dataout_q  <= '0;
            wren_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dataout_q  <= dataout_d;
            wren_q     <= wren_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Result storage; validity is tracked by count, so no reset needed
    always_ff @(posedge clk) begin
        if (push) entry_q[wr_ptr_q] <= {rout, vout};
    end

    assign dataout  = dataout_q;
    assign wren     = wren_q;
    assign overflow = overflow_q;
    assign busy     = (count_q != 2'd0) | wren_q;

endmodule

// File: tb/tb_sqrt_result_serializer.sv
// Self-checking bench for sqrt_result_serializer: a word-stream scoreboard
// built from arithmetic packing of {rout, vout}, plus cycle-stamp checks.
module tb_sqrt_result_serializer;

    localparam int DW = 48;
    localparam int VW = 128;
    localparam int RW = 129;
    localparam int NW = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [VW-1:0] vout = '0;
    logic [RW-1:0] rout = '0;
    logic          calcend = 1'b0;
    logic          full = 1'b0;
    logic [DW-1:0] dataout;
    logic          wren;
    logic          busy;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [DW-1:0] got_w[$];
    int            got_c[$];
    logic [DW-1:0] exp_w[$];

    sqrt_result_serializer #(.DATAOUT(DW), .VW(VW), .RW(RW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vout     (vout),
        .rout     (rout),
        .calcend  (calcend),
        .full     (full),
        .dataout  (dataout),
        .wren     (wren),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every FIFO write with the cycle it is visible in
    always @(negedge clk) begin
        if (reset_n && wren) begin
            got_w.push_back(dataout);
            got_c.push_back(cyc);
        end
    end

    // Reference: P = rout * 2^VW + vout, word k = (P / 2^(DW*k)) mod 2^DW
    function automatic logic [DW-1:0] exp_word(input logic [VW-1:0] v, input logic [RW-1:0] r,
                                               input int k);
        logic [NW*DW-1:0] p;
        p = '0;
        p = p + r;
        p = p << VW;
        p = p + v;
        p = p >> (DW * k);
        return p[DW-1:0];
    endfunction

    function automatic void add_result(input logic [VW-1:0] v, input logic [RW-1:0] r);
        for (int k = 0; k < NW; k++) exp_w.push_back(exp_word(v, r, k));
    endfunction

    function automatic logic [VW-1:0] rand_v();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [RW-1:0] rand_r();
        return {1'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_q();
        got_w.delete();
        got_c.delete();
        exp_w.delete();
    endtask

    // One-cycle calcend; c is the cycle stamp of the sampling edge's preceding negedge
    task automatic pulse(input logic [VW-1:0] v, input logic [RW-1:0] r, output int c);
        vout = v;
        rout = r;
        calcend = 1'b1;
        @(negedge clk);
        c = cyc;
        @(posedge clk);
        #1;
        calcend = 1'b0;
    endtask

    // Wait (bounded) for busy to drop; optionally toggle full randomly meanwhile
    task automatic drain(input bit rnd, input int budget, output int c, output bit ok);
        ok = 1'b0;
        c = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                c = cyc;
                break;
            end
            if (rnd) full = ($urandom_range(0, 3) == 0);
        end
        full = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (got_w.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        calcend = 1'b0;
        full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (wren !== 1'b0) begin n_errors++; $display("FAIL reset_wren: got %b expected 0", wren); end
        n_checks++; if (dataout !== '0) begin n_errors++; $display("FAIL reset_dataout: got %h expected 0", dataout); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
    endtask

    task automatic test_single();
        logic [VW-1:0] v;
        int c0, ce;
        bit ok;
        clear_q();
        v = 128'h0123456789ABCDEF_FEDCBA9876543210;
        pulse(v, '0, c0);
        add_result(v, '0);
        drain(1'b0, 50, ce, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL single_timeout: busy stuck high"); end
        n_checks++; if (got_w.size() != NW) begin n_errors++; $display("FAIL single_count: got %0d expected %0d", got_w.size(), NW); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_errors++; $display("FAIL single_word%0d: got %h expected %h", i, got_w[i], exp_w[i]); end
            n_checks++; if (got_c[i] != c0 + 3 + i) begin n_errors++; $display("FAIL single_cycle%0d: got %0d expected %0d", i, got_c[i], c0 + 3 + i); end
        end
        if (got_w.size() >= 3) begin
            n_checks++; if (got_w[0] !== 48'hBA9876543210) begin n_errors++; $display("FAIL single_const0: got %h expected ba9876543210", got_w[0]); end
            n_checks++; if (got_w[1] !== 48'h89ABCDEFFEDC) begin n_errors++; $display("FAIL single_const1: got %h expected 89abcdeffedc", got_w[1]); end
            n_checks++; if (got_w[2] !== 48'h000001234567) begin n_errors++; $display("FAIL single_const2: got %h expected 000001234567", got_w[2]); end
        end
        if (got_c.size() == NW) begin
            n_checks++; if (ce != got_c[NW-1] + 1) begin n_errors++; $display("FAIL single_busy_fall: got %0d expected %0d", ce, got_c[NW-1] + 1); end
        end
    endtask

    task automatic test_remainder();
        logic [RW-1:0] r;
        int c0, ce;
        bit ok;
        clear_q();
        r = '1;
        pulse('0, r, c0);
        add_result('0, r);
        drain(1'b0, 50, ce, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL rem_timeout: busy stuck high"); end
        n_checks++; if (got_w.size() != NW) begin n_errors++; $display("FAIL rem_count: got %0d expected %0d", got_w.size(), NW); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_errors++; $display("FAIL rem_word%0d: got %h expected %h", i, got_w[i], exp_w[i]); end
        end
        if (got_w.size() == NW) begin
            n_checks++; if (got_w[2] !== 48'hFFFF00000000) begin n_errors++; $display("FAIL rem_const2: got %h expected ffff00000000", got_w[2]); end
            n_checks++; if (got_w[5] !== 48'h00000001FFFF) begin n_errors++; $display("FAIL rem_const5: got %h expected 00000001ffff", got_w[5]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [VW-1:0] v;
        logic [RW-1:0] r;
        int c0, ce, s1;
        bit ok;
        clear_q();
        v = rand_v();
        r = rand_r();
        pulse(v, r, c0);
        add_result(v, r);
        wait_words(2, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_start: got %0d words expected 2", got_w.size()); end
        s1 = (got_c.size() >= 2) ? got_c[1] : 0;
        full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        full = 1'b0;
        drain(1'b0, 50, ce, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_timeout: busy stuck high"); end
        n_checks++; if (got_w.size() != NW) begin n_errors++; $display("FAIL bp_count: got %0d expected %0d", got_w.size(), NW); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_errors++; $display("FAIL bp_word%0d: got %h expected %h", i, got_w[i], exp_w[i]); end
        end
        for (int i = 2; i < got_c.size(); i++) begin
            n_checks++; if (got_c[i] != s1 + 4 + i) begin n_errors++; $display("FAIL bp_cycle%0d: got %0d expected %0d", i, got_c[i], s1 + 4 + i); end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] va, vb;
        logic [RW-1:0] ra, rb;
        int ca, cb, ce;
        bit ok;
        clear_q();
        va = rand_v(); ra = rand_r();
        vb = rand_v(); rb = rand_r();
        pulse(va, ra, ca);
        repeat (2) @(posedge clk);
        #1;
        pulse(vb, rb, cb);
        add_result(va, ra);
        add_result(vb, rb);
        drain(1'b0, 60, ce, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b_timeout: busy stuck high"); end
        n_checks++; if (got_w.size() != 2 * NW) begin n_errors++; $display("FAIL b2b_count: got %0d expected %0d", got_w.size(), 2 * NW); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, got_w[i], exp_w[i]); end
            n_checks++; if (got_c[i] != ca + 3 + i) begin n_errors++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", i, got_c[i], ca + 3 + i); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [VW-1:0] v [3];
        logic [RW-1:0] r [3];
        int c, ce;
        bit ok;
        clear_q();
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v[i] = rand_v();
            r[i] = rand_r();
            pulse(v[i], r[i], c);
        end
        add_result(v[0], r[0]);
        add_result(v[1], r[1]);
        @(negedge clk);
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (got_w.size() != 0) begin n_errors++; $display("FAIL ovf_stall: got %0d words expected 0", got_w.size()); end
        full = 1'b0;
        drain(1'b0, 60, ce, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ovf_timeout: busy stuck high"); end
        n_checks++; if (got_w.size() != 2 * NW) begin n_errors++; $display("FAIL ovf_count: got %0d expected %0d", got_w.size(), 2 * NW); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, got_w[i], exp_w[i]); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_pop_push();
        logic [VW-1:0] v [3];
        logic [RW-1:0] r [3];
        int c [3];
        int ce;
        bit ok;
        clear_q();
        for (int i = 0; i < 3; i++) begin
            v[i] = rand_v();
            r[i] = rand_r();
            add_result(v[i], r[i]);
        end
        // C is sampled on the same edge that issues the last word of A
        pulse(v[0], r[0], c[0]);
        @(posedge clk); #1;
        pulse(v[1], r[1], c[1]);
        repeat (4) @(posedge clk);
        #1;
        pulse(v[2], r[2], c[2]);
        drain(1'b0, 80, ce, ok);
        n_checks++; if (c[2] != c[0] + 7) begin n_errors++; $display("FAIL pp_align: got %0d expected %0d", c[2], c[0] + 7); end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL pp_timeout: busy stuck high"); end
        n_checks++; if (got_w.size() != 3 * NW) begin n_errors++; $display("FAIL pp_count: got %0d expected %0d", got_w.size(), 3 * NW); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_errors++; $display("FAIL pp_word%0d: got %h expected %h", i, got_w[i], exp_w[i]); end
            n_checks++; if (got_c[i] != c[0] + 3 + i) begin n_errors++; $display("FAIL pp_cycle%0d: got %0d expected %0d", i, got_c[i], c[0] + 3 + i); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] v;
        logic [RW-1:0] r;
        int c0, ce;
        bit ok;
        clear_q();
        pulse(rand_v(), rand_r(), c0);
        wait_words(4, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL rst_start: got %0d words expected 4", got_w.size()); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (wren !== 1'b0) begin n_errors++; $display("FAIL rst_wren: got %b expected 0", wren); end
        n_checks++; if (dataout !== '0) begin n_errors++; $display("FAIL rst_dataout: got %h expected 0", dataout); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (got_w.size() != 4) begin n_errors++; $display("FAIL rst_quiet: got %0d words expected 4", got_w.size()); end
        clear_q();
        v = rand_v();
        r = rand_r();
        pulse(v, r, c0);
        add_result(v, r);
        drain(1'b0, 50, ce, ok);
        n_checks++; if (got_w.size() != NW) begin n_errors++; $display("FAIL rst_after_count: got %0d expected %0d", got_w.size(), NW); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_errors++; $display("FAIL rst_after_word%0d: got %h expected %h", i, got_w[i], exp_w[i]); end
        end
    endtask

    task automatic test_random_full();
        logic [VW-1:0] v;
        logic [RW-1:0] r;
        int c0, ce;
        bit ok;
        for (int n = 0; n < 6; n++) begin
            clear_q();
            v = rand_v();
            r = rand_r();
            pulse(v, r, c0);
            add_result(v, r);
            drain(1'b1, 300, ce, ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL rnd%0d_timeout: busy stuck high", n); end
            n_checks++; if (got_w.size() != NW) begin n_errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", n, got_w.size(), NW); end
            for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
                n_checks++; if (got_w[i] !== exp_w[i]) begin n_errors++; $display("FAIL rnd%0d_word%0d: got %h expected %h", n, i, got_w[i], exp_w[i]); end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_remainder();
        test_back_pressure();
        test_back_to_back();
        test_pop_push();
        test_overflow();
        test_reset();
        test_reset_mid();
        test_random_full();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
